// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types, mode bit indices and sizing helper for the SPI master
//
// Contents:
//   spi_state_t  transfer FSM states (IDLE, SHIFT)
//   MODE_CPOL    bit index of CPOL inside the 2-bit mode word
//   MODE_CPHA    bit index of CPHA inside the 2-bit mode word
//   clog2()      ceiling log2, used to size the SCK edge counter
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

  localparam int MODE_CPOL = 1;
  localparam int MODE_CPHA = 0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// rtl/spi_clkgen.sv - SCK half-period timer for the SPI master
//
// Ports:
//   i_clk   system clock
//   i_rst   asynchronous reset, active-high
//   i_load  capture i_div and restart the half-period count
//   i_run   count while a transfer is shifting
//   i_div   half-period length minus one
//   o_tick  high on the cycle that ends a half-period
module spi_clkgen
  import spi_pkg::*;
#(
  parameter int DIVW = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_run,
  input  logic [DIVW-1:0] i_div,
  output logic            o_tick
);

  logic [DIVW-1:0] r_div;
  logic [DIVW-1:0] r_hcnt;

  // The divider is captured once so later changes on i_div cannot stretch
  // or shrink half-periods of the transfer already in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div  <= '0;
      r_hcnt <= '0;
    end else if (i_load) begin
      r_div  <= i_div;
      r_hcnt <= i_div;
    end else if (i_run) begin
      if (r_hcnt == '0) r_hcnt <= r_div;
      else              r_hcnt <= r_hcnt - DIVW'(1);
    end
  end

  assign o_tick = i_run && (r_hcnt == '0);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - word-at-a-time SPI master with SCK divider and device selects
//
// Optional feature macro: SPI_MODES_EN (all four SPI modes; otherwise fixed mode 0).
//
// Ports:
//   CLK, RST     system clock, asynchronous active-high reset
//   start        request a transfer (accepted only while busy=0)
//   din          word to send, MSB first
//   mode         {CPOL,CPHA}
//   div          SCK half-period is div+1 CLK cycles
//   cs_we/cs_in  load nSS while idle
//   MISO         per-device inputs, bit NSS is the fallback when no select is low
//   busy/done    transfer in progress / one-cycle completion pulse
//   dout         last received word
//   SCK/MOSI/nSS SPI pins
module spi_master
  import spi_pkg::*;
#(
  parameter int NSS   = 2,
  parameter int NBITS = 8,
  parameter int DIVW  = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [NBITS-1:0] din,
  input  logic [1:0]       mode,
  input  logic [DIVW-1:0]  div,
  input  logic             cs_we,
  input  logic [NSS-1:0]   cs_in,
  input  logic [NSS:0]     MISO,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] dout,
  output logic             SCK,
  output logic             MOSI,
  output logic [NSS-1:0]   nSS
);

  localparam int EW = clog2(2 * NBITS);
  localparam logic [EW-1:0] ECNT_LAST = EW'(2 * NBITS - 1);

  spi_state_t       r_state, w_state_nxt;
  logic [NBITS-1:0] r_sreg, w_sreg_nxt, w_shifted;
  logic [EW-1:0]    r_ecnt, w_ecnt_nxt;
  logic             r_sck, w_sck_nxt;
  logic             r_mosi, w_mosi_nxt;
  logic [NSS-1:0]   r_nss, w_nss_nxt;
  logic             r_done, w_done_nxt;
  logic [NBITS-1:0] r_dout, w_dout_nxt;
  logic             w_accept, w_tick, w_miso_sel, w_leading;
  logic             w_cpol, w_cpha, w_acc_cpol, w_acc_cpha;

`ifdef SPI_MODES_EN
  logic [1:0] r_mode;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           r_mode <= 2'b00;
    else if (w_accept) r_mode <= mode;
  end
  assign w_cpol     = r_mode[MODE_CPOL];
  assign w_cpha     = r_mode[MODE_CPHA];
  assign w_acc_cpol = mode[MODE_CPOL];
  assign w_acc_cpha = mode[MODE_CPHA];
`else
  logic w_unused_mode;
  assign w_unused_mode = ^mode;
  assign w_cpol     = 1'b0;
  assign w_cpha     = 1'b0;
  assign w_acc_cpol = 1'b0;
  assign w_acc_cpha = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) && start;

  spi_clkgen #(.DIVW(DIVW)) u_clkgen (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_load (w_accept),
    .i_run  (r_state == SHIFT),
    .i_div  (div),
    .o_tick (w_tick)
  );

  // With no select low the expansion-header line is used; several selects
  // low simply OR their devices together.
  assign w_miso_sel = (&r_nss) ? MISO[NSS] : |(MISO[NSS-1:0] & ~r_nss);
  assign w_shifted  = {r_sreg[NBITS-2:0], w_miso_sel};
  assign w_leading  = (r_sck == w_cpol);

  always_comb begin
    w_state_nxt = r_state;
    w_sreg_nxt  = r_sreg;
    w_ecnt_nxt  = r_ecnt;
    w_sck_nxt   = r_sck;
    w_mosi_nxt  = r_mosi;
    w_nss_nxt   = r_nss;
    w_done_nxt  = 1'b0;
    w_dout_nxt  = r_dout;
    case (r_state)
      IDLE: begin
        // Track the requested polarity so SCK is already correct before a select falls.
        w_sck_nxt = w_acc_cpol;
        if (cs_we) w_nss_nxt = cs_in;
        if (start) begin
          w_state_nxt = SHIFT;
          w_sreg_nxt  = din;
          w_ecnt_nxt  = ECNT_LAST;
          if (!w_acc_cpha) w_mosi_nxt = din[NBITS-1];
        end
      end
      SHIFT: begin
        if (w_tick) begin
          w_sck_nxt  = ~r_sck;
          w_ecnt_nxt = r_ecnt - EW'(1);
          if (w_leading) begin
            if (!w_cpha) w_sreg_nxt = w_shifted;
            else         w_mosi_nxt = r_sreg[NBITS-1];
          end else begin
            if (w_cpha)                w_sreg_nxt = w_shifted;
            else if (r_ecnt != '0)     w_mosi_nxt = r_sreg[NBITS-1];
          end
          // The last edge is always a trailing one, so SCK lands back on CPOL.
          if (r_ecnt == '0) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
            w_dout_nxt  = w_sreg_nxt;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_ecnt  <= '0;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_nss   <= '1;
      r_done  <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sreg  <= w_sreg_nxt;
      r_ecnt  <= w_ecnt_nxt;
      r_sck   <= w_sck_nxt;
      r_mosi  <= w_mosi_nxt;
      r_nss   <= w_nss_nxt;
      r_done  <= w_done_nxt;
      r_dout  <= w_dout_nxt;
    end
  end

  assign busy = (r_state == SHIFT);
  assign done = r_done;
  assign dout = r_dout;
  assign SCK  = r_sck;
  assign MOSI = r_mosi;
  assign nSS  = r_nss;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed vector bench for spi_master
module tb_spi_master;

`ifdef SPI_MODES_EN
  localparam logic MODES = 1'b1;
`else
  localparam logic MODES = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b1;
  logic       start = 1'b0, cs_we = 1'b0;
  logic [7:0] din = 8'h00;
  logic [1:0] mode = 2'b00;
  logic [3:0] div = 4'h0;
  logic [1:0] cs_in = 2'b11;
  logic [2:0] miso;
  logic       busy, done, sck, mosi;
  logic [7:0] dout;
  logic [1:0] nss;

  logic       loop_en = 1'b0, miso1 = 1'b0, pat_en = 1'b0, pat_bit;
  logic [7:0] pat = 8'h00, mosi_exp = 8'h00;
  logic       mosi_chk = 1'b0, prev_sck = 1'b0;
  int         rise_cnt = 0, done_cnt = 0;
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;

  spi_master #(.NSS(2), .NBITS(8), .DIVW(4)) dut (
    .CLK(clk), .RST(rst), .start(start), .din(din), .mode(mode), .div(div),
    .cs_we(cs_we), .cs_in(cs_in), .MISO(miso), .busy(busy), .done(done),
    .dout(dout), .SCK(sck), .MOSI(mosi), .nSS(nss)
  );

  // Bench-side SPI device: MISO[2] presents pat MSB-first, one bit per SCK rise.
  always_comb pat_bit = (rise_cnt < 8) ? pat[7 - rise_cnt] : 1'b0;
  assign miso = {pat_en & pat_bit, miso1, loop_en & mosi};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (sck && !prev_sck) begin
      if (mosi_chk && rise_cnt < 8) chk("mosi_before_rise", mosi, mosi_exp[7 - rise_cnt]);
      rise_cnt++;
    end
    prev_sck = sck;
    if (done) done_cnt++;
  end

  task automatic launch(input logic [7:0] d, input logic [1:0] m, input logic [3:0] dv,
                        input logic [1:0] cs);
    @(negedge clk);
    mode = m;
    @(negedge clk);
    @(negedge clk);
    din = d; div = dv; cs_in = cs; cs_we = 1'b1; start = 1'b1;
    rise_cnt = 0; done_cnt = 0; mosi_exp = d;
    @(posedge clk);
    #1;
    start = 1'b0; cs_we = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("nss_same_edge", nss, cs);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("done_seen", done, 1);
  endtask

  typedef struct {
    logic [7:0] din;
    logic [1:0] mode;
    logic [3:0] div;
    logic [1:0] nss;
    int         src;      // 0: loopback on MISO[0], 1: MISO[1]=1, 2: pattern on MISO[2]
    logic [7:0] pat;
    logic [7:0] exp_dout;
    int         exp_lat;
    logic       exp_idle;
  } vec_t;

  vec_t vecs[5];
  int   lat;

  initial begin
    vecs[0] = '{8'hA5, 2'b00, 4'h0, 2'b10, 0, 8'h00, 8'hA5, 16,  1'b0};
    vecs[1] = '{8'h3C, 2'b11, 4'h3, 2'b01, 1, 8'h00, 8'hFF, 64,  MODES};
    vecs[2] = '{8'h00, 2'b00, 4'h1, 2'b11, 2, 8'h5A, 8'h5A, 32,  1'b0};
    vecs[3] = '{8'h81, 2'b11, 4'h0, 2'b10, 0, 8'h00, 8'h81, 16,  MODES};
    vecs[4] = '{8'h5A, 2'b00, 4'hF, 2'b10, 0, 8'h00, 8'h5A, 256, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_nss", nss, 2'b11);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dout", dout, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      loop_en = (vecs[i].src == 0);
      miso1   = (vecs[i].src == 1);
      pat_en  = (vecs[i].src == 2);
      pat     = vecs[i].pat;
      mosi_chk = (vecs[i].mode == 2'b00) || (vecs[i].mode == 2'b11);
      launch(vecs[i].din, vecs[i].mode, vecs[i].div, vecs[i].nss);
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_dout", i), dout, vecs[i].exp_dout);
      chk($sformatf("v%0d_busy_at_done", i), busy, 0);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_done_pulses", i), done_cnt, 1);
      chk($sformatf("v%0d_sck_rises", i), rise_cnt, 8);
      chk($sformatf("v%0d_idle_sck", i), sck, vecs[i].exp_idle);
    end

    // Restart attempt and select write while busy must both be ignored.
    loop_en = 1'b1; miso1 = 1'b0; pat_en = 1'b0; mosi_chk = 1'b1;
    launch(8'hA5, 2'b00, 4'h0, 2'b10);
    repeat (4) @(posedge clk);
    #2;
    start = 1'b1; din = 8'hFF; cs_we = 1'b1; cs_in = 2'b00;
    @(posedge clk);
    #1;
    start = 1'b0; cs_we = 1'b0;
    chk("busy_nss_held", nss, 2'b10);
    wait_done(lat);
    chk("ignored_start_latency", lat, 11);
    chk("ignored_start_dout", dout, 8'hA5);
    repeat (3) @(negedge clk);
    chk("ignored_start_pulses", done_cnt, 1);
    chk("ignored_start_no_queue", busy, 0);

    // Reset in the middle of a transfer.
    launch(8'h3C, 2'b00, 4'h0, 2'b10);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_sck", sck, 0);
    chk("midrst_mosi", mosi, 0);
    chk("midrst_nss", nss, 2'b11);
    chk("midrst_busy", busy, 0);
    chk("midrst_dout", dout, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_no_done", done_cnt, 0);
    launch(8'hC3, 2'b00, 4'h0, 2'b10);
    wait_done(lat);
    chk("post_rst_latency", lat, 16);
    chk("post_rst_dout", dout, 8'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
